// File: rtl/mem_resp_demux_pkg.sv
// Shared definitions for the memory response demux: requester selects, FSM encodings
// and the latched request record.
package mem_resp_demux_pkg;

  localparam logic SEL_INSTR = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef struct packed {
    logic sel;
    logic write;
  } req_t;

  // A fetch can never write, so an illegal fetch-write is demoted to a fetch read.
  function automatic req_t make_req(input logic sel, input logic write);
    req_t r;
    r.sel   = sel;
    r.write = write & (sel == SEL_DATA);
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_demux_timer.sv
// Watchdog for a memory access: counts WAIT cycles without completion and flags the
// cycle in which the access must be abandoned. TIMEOUT=0 disables it.
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  input  logic done,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST    = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] SAT_MAX = '1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !done && (count_q != SAT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TIMEOUT != 0) && run && !done && (count_q == LAST);

endmodule

// File: rtl/mem_resp_demux.sv
// Tracks one memory access at a time and routes the returned data to the instruction
// or data register of the requester that issued it.
module mem_resp_demux
  import mem_resp_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sel,
  input  logic                  req_write,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  timeout
);

  logic [0:0]            state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic                  timeout_q, timeout_d;
  logic                  in_wait, accept, expired;

  assign in_wait   = (state_q == ST_WAIT);
  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_ready & req_valid;

  assign mem_read  = in_wait & ~req_q.write;
  assign mem_write = in_wait &  req_q.write;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .run     (in_wait),
    .done    (input_ready),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    instr_d       = instr_q;
    data_d        = data_q;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    timeout_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          req_d   = make_req(req_sel, req_write);
        end
      end
      ST_WAIT: begin
        // Completion beats the watchdog when both land in the same cycle.
        if (input_ready) begin
          state_d = ST_IDLE;
          if (req_q.write) begin
            data_valid_d = 1'b1;
          end else if (req_q.sel == SEL_DATA) begin
            data_d       = mem_rdata;
            data_valid_d = 1'b1;
          end else begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
          end
        end else if (expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      instr_q       <= '0;
      data_q        <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      instr_q       <= instr_d;
      data_q        <= data_d;
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign instr_out   = instr_q;
  assign data_out    = data_q;
  assign instr_valid = instr_valid_q;
  assign data_valid  = data_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_resp_demux.sv
// Bench for mem_resp_demux: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_mem_resp_demux;

  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_sel = 1'b0, req_write = 1'b0, input_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          req_ready, mem_read, mem_write, instr_valid, data_valid, timeout;
  logic [DW-1:0] instr_out, data_out;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: one outstanding access with its age in WAIT cycles, plus the visible registers.
  bit          busy = 1'b0, m_sel = 1'b0, m_wr = 1'b0;
  int          age = 0;
  bit [DW-1:0] e_instr = '0, e_data = '0;
  bit          e_iv = 1'b0, e_dv = 1'b0, e_to = 1'b0;

  mem_resp_demux #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_write   (req_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .input_ready (input_ready),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy = 0; m_sel = 0; m_wr = 0; age = 0;
      e_instr = '0; e_data = '0; e_iv = 0; e_dv = 0; e_to = 0;
    end else begin
      e_iv = 0; e_dv = 0; e_to = 0;
      if (!busy) begin
        if (req_valid) begin
          busy = 1; m_sel = req_sel; m_wr = req_sel & req_write; age = 0;
        end
      end else if (input_ready) begin
        busy = 0;
        if (m_wr) e_dv = 1;
        else if (m_sel) begin e_data = mem_rdata; e_dv = 1; end
        else begin e_instr = mem_rdata; e_iv = 1; end
      end else if (TO != 0 && age + 1 == TO) begin
        busy = 0; e_to = 1;
      end else begin
        age++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("req_ready",   32'(req_ready),   32'(!busy));
      check_output("mem_read",    32'(mem_read),    32'(busy && !m_wr));
      check_output("mem_write",   32'(mem_write),   32'(busy && m_wr));
      check_output("instr_out",   32'(instr_out),   32'(e_instr));
      check_output("data_out",    32'(data_out),    32'(e_data));
      check_output("instr_valid", 32'(instr_valid), 32'(e_iv));
      check_output("data_valid",  32'(data_valid),  32'(e_dv));
      check_output("timeout",     32'(timeout),     32'(e_to));
    end
  end

  task automatic apply_stimulus(input logic v, input logic s, input logic w, input logic ir,
                                input logic [DW-1:0] rd);
    req_valid = v; req_sel = s; req_write = w; input_ready = ir; mem_rdata = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; input_ready = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset in the middle of an access abandons it immediately.
    apply_stimulus(1, 1, 0, 0, '0);
    check_output("rst_pre_mem_read", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_mem_read", 32'(mem_read), 32'd0);
    check_output("rst_outs", {instr_out, data_out}, 32'd0);
    check_output("rst_pulses", {29'd0, instr_valid, data_valid, timeout}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fetch with completion three cycles into WAIT.
    apply_stimulus(1, 0, 0, 0, '0);
    check_output("fetch_rd_n1", 32'(mem_read), 32'd1);
    apply_stimulus(0, 0, 0, 0, '0);
    check_output("fetch_rd_n2", 32'(mem_read), 32'd1);
    apply_stimulus(0, 0, 0, 0, '0);
    check_output("fetch_rd_n3", 32'(mem_read), 32'd1);
    apply_stimulus(0, 0, 0, 1, 16'hA5C3);
    check_output("fetch_instr", 32'(instr_out), 32'h0000A5C3);
    check_output("fetch_iv", 32'(instr_valid), 32'd1);
    check_output("fetch_data", 32'(data_out), 32'd0);
    check_output("fetch_rd_off", 32'(mem_read), 32'd0);
    apply_stimulus(0, 0, 0, 0, '0);
    check_output("fetch_iv_once", 32'(instr_valid), 32'd0);

    // Load at minimum latency, then a store accepted on the returning ready cycle.
    apply_stimulus(1, 1, 0, 0, '0);
    apply_stimulus(0, 0, 0, 1, 16'h0042);
    check_output("load_data", 32'(data_out), 32'h00000042);
    check_output("load_dv", 32'(data_valid), 32'd1);
    check_output("load_ready", 32'(req_ready), 32'd1);
    apply_stimulus(1, 1, 1, 0, '0);
    check_output("store_wr", 32'(mem_write), 32'd1);
    check_output("store_rd", 32'(mem_read), 32'd0);
    apply_stimulus(0, 0, 0, 0, '0);
    check_output("store_wr_hold", 32'(mem_write), 32'd1);
    apply_stimulus(0, 0, 0, 1, 16'hFFFF);
    check_output("store_dv", 32'(data_valid), 32'd1);
    check_output("store_data", 32'(data_out), 32'h00000042);

    // Watchdog expiry with no completion.
    apply_stimulus(1, 1, 0, 0, '0);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(0, 0, 0, 0, '0);
      if (timeout && k == 0) k = i;
      check_output("to_no_dv", 32'(data_valid), 32'd0);
    end
    check_output("to_latency", 32'(k), 32'd4);

    // Completion in the expiry cycle wins.
    apply_stimulus(1, 1, 0, 0, '0);
    repeat (3) apply_stimulus(0, 0, 0, 0, '0);
    apply_stimulus(0, 0, 0, 1, 16'h1234);
    check_output("race_dv", 32'(data_valid), 32'd1);
    check_output("race_to", 32'(timeout), 32'd0);
    check_output("race_data", 32'(data_out), 32'h00001234);

    // Spurious completion while idle.
    apply_stimulus(0, 0, 0, 0, '0);
    apply_stimulus(0, 0, 0, 1, 16'hFFFF);
    check_output("spur_instr", 32'(instr_out), 32'h0000A5C3);
    check_output("spur_data", 32'(data_out), 32'h00001234);
    check_output("spur_pulses", {29'd0, instr_valid, data_valid, timeout}, 32'd0);

    // Illegal fetch-write is treated as a fetch read.
    apply_stimulus(1, 0, 1, 0, '0);
    check_output("ill_rd", 32'(mem_read), 32'd1);
    check_output("ill_wr", 32'(mem_write), 32'd0);
    apply_stimulus(0, 0, 0, 1, 16'h0BAD);
    check_output("ill_iv", 32'(instr_valid), 32'd1);
    check_output("ill_instr", 32'(instr_out), 32'h00000BAD);

    // Random traffic checked by the per-cycle compare against the model.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     DW'($urandom));
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
